// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC controller: opcodes, state codes,
// memory-command and write-back-select encodings.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_HALT    = 2'b00;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    VSEL_MDATA = 2'b00,
    VSEL_IMM8  = 2'b01,
    VSEL_PC    = 2'b10,
    VSEL_C     = 2'b11
  } vsel_e;

  typedef logic [4:0] state_t;

  localparam state_t S_RST   = 5'd0;
  localparam state_t S_IF1   = 5'd1;
  localparam state_t S_IF2   = 5'd2;
  localparam state_t S_UPC   = 5'd3;
  localparam state_t S_DEC   = 5'd4;
  localparam state_t S_WIMM  = 5'd5;
  localparam state_t S_GETA  = 5'd6;
  localparam state_t S_GETB  = 5'd7;
  localparam state_t S_EXEC  = 5'd8;
  localparam state_t S_WREG  = 5'd9;
  localparam state_t S_ADDR  = 5'd10;
  localparam state_t S_LADDR = 5'd11;
  localparam state_t S_MRD   = 5'd12;
  localparam state_t S_WMEM  = 5'd13;
  localparam state_t S_GETD  = 5'd14;
  localparam state_t S_STRC  = 5'd15;
  localparam state_t S_MWR   = 5'd16;
  localparam state_t S_HALT  = 5'd17;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller-to-datapath/memory bundle: instruction data in, every datapath
// and fetch control out. master = controller, slave = datapath/memory side.
interface cpu_controller_if;
  logic [15:0] mdata;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic        bypass;
  logic        load_ir;
  logic        load_pc;
  logic        reset_pc;
  logic        load_addr;
  logic        addr_sel;
  logic [1:0]  mem_cmd;
  logic        halted;

  modport master (
    input  mdata,
    output readnum, writenum, vsel, loada, loadb, loadc, loads, write,
           asel, bsel, shift, ALUop, sximm5, sximm8, bypass, load_ir,
           load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
  );

  modport slave (
    output mdata,
    input  readnum, writenum, vsel, loada, loadb, loadc, loads, write,
           asel, bsel, shift, ALUop, sximm5, sximm8, bypass, load_ir,
           load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decode: field split, sign extension and class flags.
// LDR/STR are only recognised when MEM_OPS_EN is defined.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_alu,
  output logic        is_ldr,
  output logic        is_str,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = sext5(ir[4:0]);
  assign sximm8 = sext8(ir[7:0]);

  assign is_mov_imm = (opcode == OPC_MOV)  && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV)  && (op == OP_MOV_REG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_halt    = (opcode == OPC_HALT) && (op == OP_HALT);

`ifdef MEM_OPS_EN
  assign is_ldr = (opcode == OPC_LDR) && (op == OP_MEM);
  assign is_str = (opcode == OPC_STR) && (op == OP_MEM);
`else
  assign is_ldr = 1'b0;
  assign is_str = 1'b0;
`endif

  assign is_illegal = ~(is_mov_imm | is_mov_reg | is_alu | is_ldr | is_str | is_halt);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decode and Moore control FSM for the 16-bit RISC core.
// Define MEM_OPS_EN to compile in LDR/STR and their memory-access states.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;

  logic [1:0]  op;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh;
  logic [15:0] sximm5, sximm8;
  logic        is_mov_imm, is_mov_reg, is_alu, is_ldr, is_str, is_halt, is_illegal;
  logic        is_cmp;

  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, alu_op, mem_cmd;
  logic        loada, loadb, loadc, loads, write, asel, bsel;
  logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

  instr_decoder u_dec (
    .ir         (ir),
    .op         (op),
    .rn         (rn),
    .rd         (rd),
    .sh         (sh),
    .rm         (rm),
    .sximm5     (sximm5),
    .sximm8     (sximm8),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_alu     (is_alu),
    .is_ldr     (is_ldr),
    .is_str     (is_str),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign is_cmp = is_alu && (op == OP_CMP);

  // IR only moves on the IF2 edge, so decode is stable for the whole instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (load_ir) ir <= bus.mdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:  state_next = S_IF1;
      S_IF1:  state_next = S_IF2;
      S_IF2:  state_next = S_UPC;
      S_UPC:  state_next = S_DEC;
      S_DEC: begin
        if (is_mov_imm)                      state_next = S_WIMM;
        else if (is_mov_reg)                 state_next = S_GETB;
        else if (is_alu || is_ldr || is_str) state_next = S_GETA;
        else                                 state_next = S_HALT;
      end
      S_WIMM: state_next = S_IF1;
      S_GETA: begin
`ifdef MEM_OPS_EN
        state_next = is_alu ? S_GETB : S_ADDR;
`else
        state_next = is_alu ? S_GETB : S_HALT;
`endif
      end
      S_GETB: state_next = S_EXEC;
      S_EXEC: state_next = is_cmp ? S_IF1 : S_WREG;
      S_WREG: state_next = S_IF1;
`ifdef MEM_OPS_EN
      S_ADDR:  state_next = S_LADDR;
      S_LADDR: state_next = is_ldr ? S_MRD : S_GETD;
      S_MRD:   state_next = S_WMEM;
      S_WMEM:  state_next = S_IF1;
      S_GETD:  state_next = S_STRC;
      S_STRC:  state_next = S_MWR;
      S_MWR:   state_next = S_IF1;
`endif
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  always_comb begin
    readnum   = '0;
    writenum  = '0;
    vsel      = VSEL_MDATA;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = 2'b00;
    alu_op    = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPC:  load_pc = 1'b1;
      S_WIMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      // MOV reg passes B through the ALU as 0 + B
      S_EXEC: begin
        shift = sh;
        if (is_mov_reg) begin
          asel  = 1'b1;
          loadc = 1'b1;
        end else begin
          alu_op = op;
          loads  = is_cmp;
          loadc  = ~is_cmp;
        end
      end
      S_WREG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
`ifdef MEM_OPS_EN
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LADDR: load_addr = 1'b1;
      S_MRD:   mem_cmd = MEM_READ;
      S_WMEM: begin
        mem_cmd  = MEM_READ;
        writenum = rd;
        vsel     = VSEL_MDATA;
        write    = 1'b1;
      end
      S_GETD: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      S_STRC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR: mem_cmd = MEM_WRITE;
`endif
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.readnum   = readnum;
  assign bus.writenum  = writenum;
  assign bus.vsel      = vsel;
  assign bus.loada     = loada;
  assign bus.loadb     = loadb;
  assign bus.loadc     = loadc;
  assign bus.loads     = loads;
  assign bus.write     = write;
  assign bus.asel      = asel;
  assign bus.bsel      = bsel;
  assign bus.shift     = shift;
  assign bus.ALUop     = alu_op;
  assign bus.sximm5    = sximm5;
  assign bus.sximm8    = sximm8;
  assign bus.bypass    = 1'b0;
  assign bus.load_ir   = load_ir;
  assign bus.load_pc   = load_pc;
  assign bus.reset_pc  = reset_pc;
  assign bus.load_addr = load_addr;
  assign bus.addr_sel  = addr_sel;
  assign bus.mem_cmd   = mem_cmd;
  assign bus.halted    = halted;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and control FSM for the 16-bit RISC core. It sits directly upstream of `datapath`, driving every datapath control input (register numbers, mux selects, load enables, ALU/shift ops, sign-extended immediates). It also drives the PC/address-register and memory command strobes for the fetch–decode–execute loop.

## Interface
- No parameters.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `mdata` in 16: memory read data; instruction source for the IR.
- `readnum`, `writenum` out 3 each: register file read and write indices.
- `vsel` out 2: datapath write-back source select.
  - 00 = mdata, 01 = sximm8, 10 = PC, 11 = C.
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1 each: datapath load and write enables.
- `asel`, `bsel` out 1 each: A/B operand selects.
  - `asel` 1 = zero.
  - `bsel` 1 = sximm5.
- `shift`, `ALUop` out 2 each: shifter and ALU operation.
- `sximm5`, `sximm8` out 16 each: sign-extended `ir[4:0]` and `ir[7:0]`.
- `bypass` out 1: tied 0.
- `load_ir`, `load_pc`, `reset_pc`, `load_addr`, `addr_sel` out 1 each: fetch/address control.
  - `addr_sel` 1 = PC, 0 = address register.
- `mem_cmd` out 2: memory command. 00 NONE, 01 READ, 10 WRITE.
- `halted` out 1: high in HALT state.

## Operation
- **IR.** 16-bit register. Loads `mdata` when `load_ir` is high; cleared to 0 by reset.
- **Field decode** (from IR): opcode `[15:13]`, op `[12:11]`, Rn `[10:8]`, Rd `[7:5]`, sh `[4:3]`, Rm `[2:0]`.
- **Instruction set:**
  - MOV imm: 110/10
  - MOV reg: 110/00
  - ALU: 101/op, with op 00 ADD, 01 CMP, 10 AND, 11 MVN
  - LDR: 011/00
  - STR: 100/00
  - HALT: 111/00
  - Any other code is illegal and goes to HALT.
- **Output model.** Moore: outputs are a combinational function of the registered state and the IR. Every output not listed for a state is 0 (`mem_cmd` NONE).
- **States, outputs and transitions:**
  - RST: `reset_pc`=1, `load_pc`=1 → IF1.
  - IF1: `addr_sel`=1, READ → IF2.
  - IF2: `addr_sel`=1, READ, `load_ir`=1 → UPC.
  - UPC: `load_pc`=1 → DEC.
  - DEC: no outputs. Branches on decode:
    - MOV imm → WIMM
    - MOV reg → GETB
    - ALU, LDR, STR → GETA
    - HALT or illegal → HALT
  - WIMM: `writenum`=Rn, `vsel`=01, `write`=1 → IF1.
  - GETA: `readnum`=Rn, `loada`=1. ALU → GETB; LDR/STR → ADDR.
  - GETB: `readnum`=Rm, `loadb`=1 → EXEC.
  - EXEC: `shift`=sh, `ALUop`=op, `loadc`=1; `asel`=1 for MOV reg (which also forces `ALUop`=00). CMP: `loads`=1, `loadc`=0 → IF1. Others → WREG.
  - WREG: `writenum`=Rd, `vsel`=11, `write`=1 → IF1.
  - ADDR: `bsel`=1, `ALUop`=00, `loadc`=1 → LADDR.
  - LADDR: `load_addr`=1. LDR → MRD; STR → GETD.
  - MRD: `addr_sel`=0, READ → WMEM.
  - WMEM: `addr_sel`=0, READ, `writenum`=Rd, `vsel`=00, `write`=1 → IF1.
  - GETD: `readnum`=Rd, `loadb`=1 → STRC.
  - STRC: `asel`=1, `shift`=00, `ALUop`=00, `loadc`=1 → MWR.
  - MWR: `addr_sel`=0, WRITE → IF1.
  - HALT: `halted`=1; stays in HALT until reset.
- **Sign extension:** `sximm5` = {11{ir[4]}, ir[4:0]}; `sximm8` = {8{ir[7]}, ir[7:0]}.

## Timing
- **Reset.** Any edge with `reset`=1 sets state to RST and IR to 0; reset wins over every other transition.
- **Outputs in RST:** `reset_pc`=1, `load_pc`=1, all else 0, `halted`=0, `sximm5`=`sximm8`=0.
- **Mid-instruction reset:** aborts immediately. No `write` or WRITE command is issued after that edge; a partially executed STR never reaches MWR.
- **Memory read timing:** synchronous. Data is valid in the cycle after READ is first presented. The IR captures on the IF2 edge; the register file captures `mdata` on the WMEM edge.
- **Cycles per instruction, IF1 to return-to-IF1:**
  - MOV imm: 5
  - MOV reg: 7
  - CMP: 7
  - ADD/AND/MVN: 8
  - LDR: 9
  - STR: 10
- **IR stability:** IR changes only at IF2, so decode fields are stable for the whole instruction.

## Configuration
- **`MEM_OPS_EN` defined:** LDR/STR decode and the ADDR, LADDR, MRD, WMEM, GETD, STRC and MWR states are compiled in.
- **`MEM_OPS_EN` undefined:** those states are absent. LDR/STR codes are illegal and go to HALT. `load_addr` is tied 0, and `mem_cmd` never equals WRITE.

## Structure
- **Shared package `cpu_pkg`:**
  - state enum
  - opcode/op constants
  - `mem_cmd` encodings (NONE, READ, WRITE)
  - `vsel` encodings
- **Sub-module `instr_decoder`:** combinational. Takes IR and produces field extraction, sign extension and instruction-class flags (`is_mov_imm`, `is_mov_reg`, `is_alu`, `is_ldr`, `is_str`, `is_halt`, `is_illegal`).
- **`cpu_controller`:** holds the IR, the state register and the output decode.

## Test plan
- **Reset, then MOV imm.** Reset, `mdata`=0xD007 (MOV R0,#7).
  - RST: `reset_pc`=`load_pc`=1. IF2: `load_ir`=1.
  - WIMM in cycle 5: `writenum`=0, `vsel`=01, `write`=1, `sximm8`=0x0007.
- **Negative immediate.** 0xD1FE (MOV R1,#-2) → `sximm8`=0xFFFE.
- **ADD with shift.** 0xA148 (ADD R2,R1,R0,LSL#1):
  - GETA `readnum`=1; GETB `readnum`=0.
  - EXEC `shift`=01, `ALUop`=00, `loadc`=1.
  - WREG `writenum`=2, `vsel`=11.
  - Total 8 cycles.
- **CMP.** 0xA900 (CMP R1,R0) → EXEC `loads`=1, `loadc`=0; no `write` pulse; back in IF1 after 7 cycles.
- **LDR then STR** (`MEM_OPS_EN`):
  - 0x6164 (LDR R3,[R1,#4]): `sximm5`=4; ADDR `bsel`=1; MRD `addr_sel`=0, `mem_cmd`=01; WMEM `writenum`=3, `vsel`=00, `write`=1.
  - 0x8164 (STR): GETD `readnum`=3; MWR `mem_cmd`=10.
  - With the macro undefined, 0x6164 → `halted`=1.
- **HALT, illegal code and mid-STR reset.**
  - 0xE000 → `halted`=1 held for 20 cycles with `mem_cmd`=00.
  - 0xF800 (illegal) → HALT.
  - `reset` asserted during GETD of a STR → next cycle RST, `mem_cmd` never 10.
